// File: rtl/secded_pkg.sv
// SECDED layout helpers shared by the syndrome/decoder (and a future encoder).
// Hamming positions 1..CODE_W-1 (powers of two are check bits), overall parity at CODE_W.
package secded_pkg;

   typedef enum logic [1:0] {ST_CLEAN, ST_SINGLE, ST_DOUBLE} status_t;

   function automatic int par_w(input int data_w);
      int r;
      r = 0;
      for (int i = 20; i >= 1; i--) begin
         if ((1 << i) >= data_w + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic int code_w(input int data_w);
      return data_w + par_w(data_w) + 1;
   endfunction

   function automatic bit is_pow2(input int p);
      return (p != 0) && ((p & (p - 1)) == 0);
   endfunction

   // Hamming position of data bit k (1-based); data[1] lands on position 3.
   function automatic int data_pos(input int k);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 1; p < 256; p++) begin
         if (!is_pow2(p)) begin
            cnt++;
            if (cnt == k && pos == 0) pos = p;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational SECDED front end: codeword -> Hamming syndrome, overall parity, raw data.
// Zero latency; no flow control of its own.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter  int DATA_W = 7,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CODE_W = code_w(DATA_W)
) (
   input  logic [CODE_W:1]  code,
   output logic [PAR_W-1:0] syn,
   output logic             par,
   output logic [DATA_W:1]  raw
);

   always_comb begin
      syn = '0;
      for (int p = 1; p < CODE_W; p++) begin
         if (code[p]) syn = syn ^ PAR_W'(p);
      end
   end

   assign par = ^code;

   for (genvar k = 1; k <= DATA_W; k++) begin : g_raw
      assign raw[k] = code[data_pos(k)];
   end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage valid/ready SECDED decoder with saturating error counters; latency 2, 1 word/cycle.
// Each stage loads when empty or when its successor advances; in_ready falls only when both stages are full and stalled.
module secded_stream_decoder
   import secded_pkg::*;
#(
   parameter  int DATA_W = 7,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CODE_W = code_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W:1]   in_code,
   input  logic              correct_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:1]   out_data,
   output logic [PAR_W-1:0]  out_syn,
   output logic [PAR_W:0]    out_err_pos,
   output logic              out_single,
   output logic              out_double,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   localparam logic [PAR_W:0] CODE_POS = (PAR_W+1)'(CODE_W);

   logic [PAR_W-1:0] syn;
   logic             par;
   logic [DATA_W:1]  raw;

   logic             v1;
   logic [PAR_W-1:0] s1_syn;
   logic             s1_par;
   logic [DATA_W:1]  s1_raw;
   logic             s1_ce;

   logic             adv1;
   logic             adv2;
   logic             out_hs;
   status_t          st;
   logic [PAR_W:0]   pos;
   logic             flip_en;
   logic [DATA_W:1]  corr;

   secded_syndrome #(.DATA_W(DATA_W)) u_syn (
      .code (in_code),
      .syn  (syn),
      .par  (par),
      .raw  (raw)
   );

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !v1 || adv2;
   assign in_ready = adv1;
   assign out_hs   = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         s1_syn <= '0;
         s1_par <= 1'b0;
         s1_raw <= '0;
         s1_ce  <= 1'b0;
      end else if (adv1) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_syn <= syn;
            s1_par <= par;
            s1_raw <= raw;
            s1_ce  <= correct_en;
         end
      end
   end

   // Syndromes at or beyond CODE_W with odd parity cannot name a real bit.
   always_comb begin
      st  = ST_CLEAN;
      pos = '0;
      if (s1_par) begin
         if (s1_syn == '0) begin
            st  = ST_SINGLE;
            pos = CODE_POS;
         end else if ({1'b0, s1_syn} < CODE_POS) begin
            st  = ST_SINGLE;
            pos = {1'b0, s1_syn};
         end else begin
            st = ST_DOUBLE;
         end
      end else if (s1_syn != '0) begin
         st = ST_DOUBLE;
      end
   end

   assign flip_en = s1_ce && (st == ST_SINGLE);

   for (genvar k = 1; k <= DATA_W; k++) begin : g_corr
      localparam logic [PAR_W:0] DP = (PAR_W+1)'(data_pos(k));
      assign corr[k] = s1_raw[k] ^ (flip_en && (pos == DP));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_syn     <= '0;
         out_err_pos <= '0;
         out_single  <= 1'b0;
         out_double  <= 1'b0;
      end else if (adv2) begin
         out_valid <= v1;
         if (v1) begin
            out_data    <= corr;
            out_syn     <= s1_syn;
            out_err_pos <= pos;
            out_single  <= (st == ST_SINGLE);
            out_double  <= (st == ST_DOUBLE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (out_hs) begin
         if (out_single && (corr_cnt != '1))   corr_cnt   <= corr_cnt + 1'b1;
         if (out_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
   end

endmodule
